// File: rtl/tmr_voter_monitor_if.sv
// Replica buses in, voted bus and pairwise disagreement flags out.
interface tmr_voter_monitor_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] voted_o;
  logic [2:0]       mismatch_o;

  modport master (
    output in_a, in_b, in_c,
    input  voted_o, mismatch_o
  );

  modport slave (
    input  in_a, in_b, in_c,
    output voted_o, mismatch_o
  );
endinterface

// File: rtl/tmr_voter_monitor.sv
// TMR voter with outlier persistence filter, health FSM and resync handshake.
// Optional fault-injection ports behind TMR_VOTER_ERR_INJECT_EN.
module tmr_voter_monitor #(
  parameter int WIDTH     = 32,
  parameter int PERSIST   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tmr_voter_monitor_if.slave   bus,
  input  logic                 clear_i,
  input  logic                 resync_ack_i,
`ifdef TMR_VOTER_ERR_INJECT_EN
  input  logic [2:0]           inject_sel_i,
  input  logic [WIDTH-1:0]     inject_mask_i,
`endif
  output logic [2:0]           replica_fault_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] error_count_o,
  output logic                 resync_req_o
);

  localparam int PCW = $clog2(PERSIST + 1);
  localparam logic [PCW-1:0] PMAX = PCW'(PERSIST);

  localparam logic [1:0] NORMAL   = 2'b00;
  localparam logic [1:0] DEGRADED = 2'b01;
  localparam logic [1:0] FAILED   = 2'b10;

  logic [WIDTH-1:0] ra, rb, rc;

`ifdef TMR_VOTER_ERR_INJECT_EN
  assign ra = bus.in_a ^ (inject_sel_i[0] ? inject_mask_i : '0);
  assign rb = bus.in_b ^ (inject_sel_i[1] ? inject_mask_i : '0);
  assign rc = bus.in_c ^ (inject_sel_i[2] ? inject_mask_i : '0);
`else
  assign ra = bus.in_a;
  assign rb = bus.in_b;
  assign rc = bus.in_c;
`endif

  logic [1:0]           state_q, state_d;
  logic [2:0]           fault_q, fault_d;
  logic                 req_q, req_d;
  logic [PCW-1:0]       dis_q, dis_d;
  logic [PCW-1:0]       pcnt_q [3];
  logic [PCW-1:0]       pcnt_d [3];
  logic [WIDTH-1:0]     voted_q, voted_d;
  logic [2:0]           mism_q, mism_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;

  logic [2:0]       outl;
  logic [2:0]       hit;
  logic [2:0]       deg_flt;
  logic             h_diff;
  logic [WIDTH-1:0] h_sel;

  // Outlier: differs from both others on a bit where those two agree.
  assign outl[0] = |((ra ^ rb) & (ra ^ rc));
  assign outl[1] = |((rb ^ ra) & (rb ^ rc));
  assign outl[2] = |((rc ^ ra) & (rc ^ rb));

  assign mism_d  = {|(ra ^ rc), |(rb ^ rc), |(ra ^ rb)};
  assign deg_flt = (state_q == DEGRADED) ? fault_q : 3'b000;

  always_comb begin
    h_diff = |(ra ^ rb);
    h_sel  = ra;
    unique case (1'b1)
      deg_flt[0]: begin
        h_diff = |(rb ^ rc);
        h_sel  = rb;
      end
      deg_flt[1]: begin
        h_diff = |(ra ^ rc);
        h_sel  = ra;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= NORMAL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    req_d   = req_q;
    dis_d   = dis_q;
    hit     = 3'b000;
    for (int k = 0; k < 3; k++) pcnt_d[k] = pcnt_q[k];
    if (req_q && resync_ack_i) begin
      state_d = NORMAL;
      fault_d = 3'b000;
      req_d   = 1'b0;
      dis_d   = '0;
      for (int k = 0; k < 3; k++) pcnt_d[k] = '0;
    end else begin
      case (state_q)
        NORMAL: begin
          for (int k = 0; k < 3; k++) begin
            if (!outl[k])              pcnt_d[k] = '0;
            else if (pcnt_q[k] != PMAX) pcnt_d[k] = pcnt_q[k] + 1'b1;
            hit[k] = (pcnt_d[k] == PMAX);
          end
          if (hit != 3'b000) begin
            fault_d = hit;
            req_d   = 1'b1;
            state_d = $onehot(hit) ? DEGRADED : FAILED;
          end
        end
        DEGRADED: begin
          if (!h_diff)          dis_d = '0;
          else if (dis_q != PMAX) dis_d = dis_q + 1'b1;
          if (dis_d == PMAX) state_d = FAILED;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    voted_d = voted_q;
    case (state_q)
      NORMAL:   voted_d = (ra & rb) | (rb & rc) | (ra & rc);
      DEGRADED: voted_d = h_sel;
      default:  voted_d = voted_q;
    endcase
    err_d = err_q;
    if (clear_i)                       err_d = '0;
    else if (|mism_d && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 3'b000;
      req_q   <= 1'b0;
      dis_q   <= '0;
      voted_q <= '0;
      mism_q  <= 3'b000;
      err_q   <= '0;
      for (int k = 0; k < 3; k++) pcnt_q[k] <= '0;
    end else begin
      fault_q <= fault_d;
      req_q   <= req_d;
      dis_q   <= dis_d;
      voted_q <= voted_d;
      mism_q  <= mism_d;
      err_q   <= err_d;
      for (int k = 0; k < 3; k++) pcnt_q[k] <= pcnt_d[k];
    end
  end

  assign bus.voted_o     = voted_q;
  assign bus.mismatch_o  = mism_q;
  assign replica_fault_o = fault_q;
  assign state_o         = state_q;
  assign error_count_o   = err_q;
  assign resync_req_o    = req_q;

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Randomised and directed bench for tmr_voter_monitor.
// Expected values come from an integer-level model of the voting rules.
module tb_tmr_voter_monitor;
  localparam int W  = 32;
  localparam int P  = 4;
  localparam int CW = 8;
  localparam int EMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic clear_i;
  logic resync_ack_i;
  logic [2:0]    replica_fault_o;
  logic [1:0]    state_o;
  logic [CW-1:0] error_count_o;
  logic          resync_req_o;

  always #5 clk = ~clk;

  tmr_voter_monitor_if #(.WIDTH(W)) bus ();

  tmr_voter_monitor #(
    .WIDTH(W), .PERSIST(P), .CNT_WIDTH(CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .clear_i         (clear_i),
    .resync_ack_i    (resync_ack_i),
`ifdef TMR_VOTER_ERR_INJECT_EN
    .inject_sel_i    (3'b000),
    .inject_mask_i   ({W{1'b0}}),
`endif
    .replica_fault_o (replica_fault_o),
    .state_o         (state_o),
    .error_count_o   (error_count_o),
    .resync_req_o    (resync_req_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  int         m_pc [3];
  int         m_st;
  int         m_dis;
  bit [2:0]   m_flt;
  bit         m_req;
  logic [W-1:0] m_vot;
  bit [2:0]   m_mm;
  int         m_err;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_pc[k] = 0;
    m_st = 0; m_dis = 0; m_flt = 0; m_req = 0;
    m_vot = '0; m_mm = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [W-1:0] a, b, c,
                            input bit clr, ack);
    logic [W-1:0] r [3];
    bit [2:0] oc;
    int n, h0, h1;
    r[0] = a; r[1] = b; r[2] = c;
    m_mm = {a != c, b != c, a != b};
    if (clr) m_err = 0;
    else if (m_mm != 0 && m_err < EMAX) m_err++;
    if (m_st == 0) begin
      for (int i = 0; i < W; i++)
        m_vot[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    end else if (m_st == 1) begin
      for (int k = 2; k >= 0; k--)
        if (!m_flt[k]) m_vot = r[k];
    end
    oc = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < W; i++)
        if (r[(k+1)%3][i] == r[(k+2)%3][i] && r[k][i] != r[(k+1)%3][i])
          oc[k] = 1;
    if (m_req && ack) begin
      m_st = 0; m_flt = 0; m_req = 0; m_dis = 0;
      for (int k = 0; k < 3; k++) m_pc[k] = 0;
    end else if (m_st == 0) begin
      n = 0;
      for (int k = 0; k < 3; k++) begin
        m_pc[k] = oc[k] ? ((m_pc[k] < P) ? m_pc[k] + 1 : P) : 0;
        if (m_pc[k] == P) begin m_flt[k] = 1; n++; end
      end
      if (n > 0) begin m_req = 1; m_st = (n == 1) ? 1 : 2; end
    end else if (m_st == 1) begin
      h0 = -1; h1 = -1;
      for (int k = 0; k < 3; k++)
        if (!m_flt[k]) begin
          if (h0 < 0) h0 = k; else h1 = k;
        end
      if (r[h0] != r[h1]) m_dis = (m_dis < P) ? m_dis + 1 : P;
      else m_dis = 0;
      if (m_dis == P) m_st = 2;
    end
  endtask

  task automatic cmp_all();
    check("voted",  bus.voted_o,     m_vot);
    check("mism",   bus.mismatch_o,  m_mm);
    check("fault",  replica_fault_o, m_flt);
    check("state",  state_o,         m_st);
    check("errcnt", error_count_o,   m_err);
    check("req",    resync_req_o,    m_req);
  endtask

  task automatic cyc(input logic [W-1:0] a, b, c,
                     input bit clr, ack);
    bus.in_a = a; bus.in_b = b; bus.in_c = c;
    clear_i = clr; resync_ack_i = ack;
    @(posedge clk);
    #1;
    model_step(a, b, c, clr, ack);
    cmp_all();
  endtask

  logic [W-1:0] v, base;

  initial begin
    rst = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
    clear_i = 0; resync_ack_i = 0;
    model_reset();
    #12;
    cmp_all();
    rst = 1'b1;

    v = 32'hA5A5_0000;
    for (int i = 0; i < 10; i++) cyc(v, v, v, 0, 0);
    check("t1_voted", bus.voted_o, 32'hA5A5_0000);
    check("t1_err",   error_count_o, 0);

    for (int i = 0; i < 3; i++) begin
      cyc(v, v ^ 32'h1, v, 0, 0);
      check("t2_mism", bus.mismatch_o, 3'b011);
    end
    cyc(v, v, v, 0, 0);
    check("t2_err",   error_count_o, 3);
    check("t2_fault", replica_fault_o, 3'b000);

    for (int i = 0; i < 4; i++) cyc(v, v, v ^ 32'h8000_0000, 0, 0);
    check("t3_fault", replica_fault_o, 3'b100);
    check("t3_state", state_o, 2'b01);
    check("t3_req",   resync_req_o, 1'b1);
    cyc(32'h1234_5678, 32'h1234_5678, 32'hFFFF_0000, 0, 0);
    check("t3_voted", bus.voted_o, 32'h1234_5678);
    cyc(v, v, v, 0, 1);
    check("t3_ack_st",  state_o, 2'b00);
    check("t3_ack_flt", replica_fault_o, 3'b000);
    check("t3_ack_req", resync_req_o, 1'b0);

    for (int i = 0; i < 4; i++) cyc(v, v, ~v, 0, 0);
    for (int i = 0; i < 4; i++) cyc(v, v ^ 32'h1, ~v, 0, 0);
    check("t4_state", state_o, 2'b10);
    check("t4_req",   resync_req_o, 1'b1);
    cyc(32'h0, 32'hF, 32'h7, 0, 0);
    check("t4_frozen", bus.voted_o, v);
    cyc(v, v, v, 0, 1);

    for (int i = 0; i < EMAX + 5; i++)
      if (i % 2 == 0) cyc(v, v ^ 32'h10, v, 0, 0);
      else            cyc(v, v, v ^ 32'h20, 0, 0);
    check("t5_sat", error_count_o, EMAX);
    cyc(v, v ^ 32'h10, v, 1, 0);
    check("t5_clr", error_count_o, 0);

    for (int s = 0; s < 400; s++) begin
      int mode, len, k, k2;
      logic [W-1:0] m1, m2;
      logic [W-1:0] r [3];
      mode = $urandom_range(0, 4);
      len  = $urandom_range(1, 8);
      base = $urandom;
      k  = $urandom_range(0, 2);
      k2 = (k + $urandom_range(1, 2)) % 3;
      m1 = $urandom | 32'h1;
      m2 = $urandom | 32'h1;
      for (int t = 0; t < len; t++) begin
        r[0] = base; r[1] = base; r[2] = base;
        case (mode)
          1: r[k] = r[k] ^ m1;
          2: begin r[k] = r[k] ^ m1; r[k2] = r[k2] ^ m2; end
          3: begin r[0] = $urandom; r[1] = $urandom; r[2] = $urandom; end
          4: r[k] = r[k] ^ (32'h1 << $urandom_range(0, 31));
          default: ;
        endcase
        cyc(r[0], r[1], r[2],
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0);
      end
    end

    cyc(v, v, v, 0, 1);
    for (int i = 0; i < 4; i++) cyc(v, v ^ 32'h4, v, 0, 0);
    check("t6_deg", state_o, 2'b01);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    cmp_all();
    #3;
    rst = 1'b1;
    cyc(v, v, v, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
